// File: rtl/rv32i_pkg.sv
// Shared core definitions: datapath width and the data-memory loader FSM states.
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ldr_state_e;

  // A load length is legal when it is non-zero and fits the cache.
  function automatic logic len_legal(input logic [DPW-1:0] len,
                                     input logic [DPW-1:0] max_w);
    return (len != '0) && (len <= max_w);
  endfunction

endpackage

// File: rtl/dmem_loader.sv
// Streams len_i 32-bit words into the data cache from BASE_ADDR upward,
// holding the core in busy_o until the last word is written.
module dmem_loader
  import rv32i_pkg::*;
#(
  parameter int             DEPTH     = 120,
  parameter logic [DPW-1:0] BASE_ADDR = '0
) (
  input  logic           clk,
  input  logic           arst_ni,
  input  logic           start_i,
  input  logic [DPW-1:0] len_i,
  input  logic [DPW-1:0] s_data_i,
  input  logic           s_valid_i,
  output logic           s_ready_o,
  output logic           data_en_o,
  output logic [DPW-1:0] input_data_o,
  output logic [DPW-1:0] input_addr_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  localparam logic [DPW-1:0] MAX_WORDS = DPW'(DEPTH / 4);

  ldr_state_e     r_state;
  ldr_state_e     w_state_nxt;
  logic [DPW-1:0] r_len;
  logic [DPW-1:0] r_cnt;
  logic [DPW-1:0] r_addr;
  logic           r_data_en;
  logic [DPW-1:0] r_data;
  logic [DPW-1:0] r_waddr;
  logic           r_err;

  logic w_acc;
  logic w_last;
  logic w_start_ok;
  logic w_start_bad;

  assign w_acc       = s_valid_i && (r_state == LOAD);
  assign w_last      = w_acc && (r_cnt == (r_len - 1'b1));
  assign w_start_ok  = (r_state == IDLE) && start_i && len_legal(len_i, MAX_WORDS);
  assign w_start_bad = (r_state == IDLE) && start_i && !len_legal(len_i, MAX_WORDS);

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = LOAD;
      end
      LOAD: begin
        s_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data_en <= 1'b0;
      r_data    <= '0;
      r_waddr   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_data_en <= w_acc;
      r_err     <= w_start_bad;
      if (w_acc) begin
        r_data  <= s_data_i;
        r_waddr <= r_addr;
      end
      if (w_start_ok) begin
        r_len  <= len_i;
        r_cnt  <= '0;
        r_addr <= BASE_ADDR;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        // Hold the address on the final word so it never steps past the cache end.
        if (!w_last) r_addr <= r_addr + DPW'(4);
      end
    end
  end

  assign data_en_o    = r_data_en;
  assign input_data_o = r_data;
  assign input_addr_o = r_waddr;
  assign err_o        = r_err;

endmodule

// File: tb/tb_dmem_loader.sv
// Table-driven bench for dmem_loader with a write scoreboard.
module tb_dmem_loader;

  localparam logic [31:0] BASE = 32'h0;

  logic        clk = 1'b0;
  logic        arst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic [31:0] s_data_i = '0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o, data_en_o, busy_o, done_o, err_o;
  logic [31:0] input_data_o, input_addr_o;

  dmem_loader #(.DEPTH(120), .BASE_ADDR(BASE)) dut (
    .clk(clk), .arst_ni(arst_ni), .start_i(start_i), .len_i(len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .data_en_o(data_en_o), .input_data_o(input_data_o), .input_addr_o(input_addr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [31:0] vmask;
    bit          err;
    bit          mid;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t  q[$];
  wr_t  mon_e;
  vec_t vecs[8];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0b required=%0b", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (arst_ni) begin
      if (data_en_o) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write actual_addr=%0h required=no_write", input_addr_o);
        end else begin
          mon_e = q.pop_front();
          check("wr_addr", input_addr_o, mon_e.addr);
          check("wr_data", input_data_o, mon_e.data);
          check1("wr_done", done_o, mon_e.last);
        end
      end else begin
        check1("done_without_write", done_o, 1'b0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check1({nm, "_ready"}, s_ready_o, 1'b0);
    check1({nm, "_en"}, data_en_o, 1'b0);
    check({nm, "_data"}, input_data_o, 32'h0);
    check({nm, "_addr"}, input_addr_o, 32'h0);
    check1({nm, "_busy"}, busy_o, 1'b0);
    check1({nm, "_done"}, done_o, 1'b0);
    check1({nm, "_err"}, err_o, 1'b0);
  endtask

  task automatic run(input int vi, input int len, input logic [31:0] vm,
                     input bit err, input bit mid);
    int acc = 0;
    int i = 0;
    start_i = 1'b1;
    len_i   = 32'(len);
    cyc();
    start_i = 1'b0;
    len_i   = '0;
    if (err) begin
      check1("err_pulse", err_o, 1'b1);
      check1("err_busy", busy_o, 1'b0);
      check1("err_ready", s_ready_o, 1'b0);
      cyc();
      check1("err_clear", err_o, 1'b0);
      check1("err_busy2", busy_o, 1'b0);
    end else begin
      check1("load_busy", busy_o, 1'b1);
      check1("load_ready", s_ready_o, 1'b1);
      check1("load_err", err_o, 1'b0);
      while (acc < len && i < 200) begin
        s_valid_i = vm[i % 32];
        s_data_i  = (vi == 0) ? 32'hA + 32'(acc) : $urandom;
        if (mid && i == 1) begin
          start_i = 1'b1;
          len_i   = 32'd1;
        end else begin
          start_i = 1'b0;
          len_i   = '0;
        end
        if (s_valid_i && s_ready_o) begin
          q.push_back('{BASE + 32'(4 * acc), s_data_i, (acc == len - 1)});
          acc++;
        end
        cyc();
        i++;
      end
      s_valid_i = 1'b0;
      start_i   = 1'b0;
      check("accepted_count", 32'(acc), 32'(len));
      check1("done_state", done_o, 1'b1);
      check1("ready_drop", s_ready_o, 1'b0);
      check1("done_busy", busy_o, 1'b1);
      cyc();
      check1("idle_busy", busy_o, 1'b0);
      check1("idle_done", done_o, 1'b0);
      check1("idle_ready", s_ready_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[1] = '{2,  32'h0000_0009, 1'b0, 1'b0};
    vecs[2] = '{0,  32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{31, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{30, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{4,  32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[6] = '{7,  32'h5555_5555, 1'b0, 1'b0};
    vecs[7] = '{1,  32'h0000_0004, 1'b0, 1'b0};

    #12;
    check_all_zero("reset");
    @(negedge clk);
    arst_ni = 1'b1;
    cyc();
    check_all_zero("post_reset");

    for (int v = 0; v < 8; v++)
      run(v, vecs[v].len, vecs[v].vmask, vecs[v].err, vecs[v].mid);

    // Reset in the middle of a 5-word load.
    start_i = 1'b1;
    len_i   = 32'd5;
    cyc();
    start_i = 1'b0;
    s_valid_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_data_i = 32'hD0 + 32'(k);
      q.push_back('{BASE + 32'(4 * k), s_data_i, 1'b0});
      cyc();
    end
    @(negedge clk);
    #1 arst_ni = 1'b0;
    #1 check_all_zero("mid_reset");
    cyc();
    cyc();
    @(negedge clk);
    arst_ni   = 1'b1;
    s_valid_i = 1'b0;
    cyc();
    cyc();
    check1("abort_busy", busy_o, 1'b0);
    check("abort_queue", 32'(q.size()), 32'h0);
    run(1, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    repeat (3) cyc();
    check("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: dmem_loader

Interface
REQ-001 Parameter DEPTH, default 120, data-cache size in bytes; it SHALL match the d_cache Depth.
REQ-002 Parameter BASE_ADDR, default 0, first byte address written; it SHALL be word-aligned.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port arst_ni  input  1  reset, asynchronous and active-low.
REQ-005 Port start_i  input  1  request to begin a load; sampled only in IDLE.
REQ-006 Port len_i  input  DPW  number of 32-bit words to load; sampled with start_i.
REQ-007 Port s_data_i  input  DPW  incoming word stream.
REQ-008 Port s_valid_i  input  1  s_data_i is valid.
REQ-009 Port s_ready_o  output  1  loader accepts s_data_i this cycle.
REQ-010 Port data_en_o  output  1  d_cache write strobe (drives data_en).
REQ-011 Port input_data_o  output  DPW  d_cache write data (drives input_data).
REQ-012 Port input_addr_o  output  DPW  d_cache byte address (drives input_addr).
REQ-013 Port busy_o  output  1  load in progress; the core SHALL be held while high.
REQ-014 Port done_o  output  1  one-cycle pulse when the last word has been written.
REQ-015 Port err_o  output  1  one-cycle pulse when start_i carries an illegal len_i.

Function
REQ-016 MAX_WORDS SHALL equal DEPTH/4 (30 at default).
REQ-017 The FSM SHALL have exactly three states: IDLE, LOAD and DONE.
REQ-018 IDLE, start_i=1, 1<=len_i<=MAX_WORDS: the FSM SHALL move to LOAD, latch len_i, set the address to BASE_ADDR and clear the word counter.
REQ-019 IDLE, start_i=1, len_i=0 or len_i>MAX_WORDS: the FSM SHALL stay in IDLE and pulse err_o for one cycle the next cycle.
REQ-020 s_ready_o SHALL be 1 only in LOAD; s_valid_i SHALL be ignored outside LOAD.
REQ-021 Handshake: a word is accepted when s_valid_i&&s_ready_o; s_valid_i may deassert at any time without loss.
REQ-022 On acceptance, the next cycle SHALL show data_en_o=1, input_data_o=accepted word and input_addr_o=current address (1-cycle latency, registered outputs).
REQ-023 On each acceptance, the address SHALL increment by 4 and the counter by 1.
REQ-024 data_en_o SHALL be 0 in every cycle with no acceptance in the previous cycle.
REQ-025 Acceptance of word len (counter = len-1) SHALL move the FSM to DONE, and s_ready_o SHALL drop in that next cycle.
REQ-026 DONE SHALL last one cycle with done_o=1 (coincident with the last data_en_o) and then return to IDLE.
REQ-027 busy_o SHALL be 1 in LOAD and DONE and 0 in IDLE.
REQ-028 start_i in LOAD or DONE SHALL be ignored and SHALL NOT restart or extend the load.
REQ-029 The address SHALL never exceed BASE_ADDR+4*(MAX_WORDS-1); no wrap-around is possible.
REQ-030 start_i asserted in the cycle after DONE SHALL be accepted normally.

Reset
REQ-031 arst_ni=0 SHALL force IDLE immediately and clear all outputs to 0 (s_ready_o, data_en_o, input_data_o, input_addr_o, busy_o, done_o, err_o) and the counter and latched length, asynchronously.
REQ-032 Reset during LOAD SHALL abort the load with no further data_en_o pulses and no done_o pulse; words already written remain in the cache.
REQ-033 After arst_ni rises, the first start_i SHALL be honoured no earlier than the next rising clock edge.

Structure
REQ-034 DPW SHALL come from rv32i_pkg; the FSM state enum (IDLE, LOAD, DONE) SHALL be added to rv32i_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; its outputs SHALL connect directly to the writeback_stage data_en, input_data and input_addr ports.

Verification
REQ-036 start_i=1, len_i=3, BASE_ADDR=0, stream 0xA, 0xB, 0xC with continuous valid -> data_en_o pulses at addresses 0, 4, 8 with data 0xA, 0xB, 0xC; done_o coincides with the third pulse; busy_o then falls.
REQ-037 len_i=2 with s_valid_i toggled 1,0,0,1 -> exactly two writes (addr 0, then addr 4 three cycles later); no write in the gap cycles.
REQ-038 len_i=0 and then len_i=31 -> err_o pulses once for each; busy_o stays 0; no data_en_o.
REQ-039 len_i=30 full load -> last write at address 116, done_o=1, s_ready_o=0 the next cycle.
REQ-040 len_i=5, arst_ni low after 2 accepts -> all outputs 0 immediately; no done_o; a subsequent start_i with len_i=1 writes address 0.
REQ-041 start_i reasserted with len_i=1 mid-load of len_i=4 -> ignored; exactly 4 writes and one done_o.
